// File: rtl/multiply_divide_unit.sv
// multiply_divide_unit
//
// Multi-cycle execute-stage unit for MULT/MULTU/DIV/DIVU/MTHI/MTLO. It owns
// the architectural HI/LO registers and sits beside the single-cycle ALU.
// Multiply is radix-2 shift-add on operand magnitudes. Divide is restoring
// division on magnitudes. A final FIXUP cycle applies the result signs and
// writes HI/LO in one step, so HI/LO are never seen half-updated.
//
// Optional feature: define MDU_FAST_MULTIPLY_EN to compute MULT/MULTU with a
// single 32x32 multiplier. The product is registered at E1 and busy is high
// for one cycle. Divide is the same in both builds.
//
// Parameters
//   BITS_PER_CYCLE : bits retired per iteration cycle (1, 2 or 4).
//                    ITER = 32 / BITS_PER_CYCLE iteration cycles.
//
// Ports
//   clock      : rising-edge clock
//   resetN     : asynchronous active-low reset
//   start      : request valid for one cycle
//   operation  : MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO
//   operand1   : multiplicand / dividend / move source
//   operand2   : multiplier / divisor
//   cancel     : pipeline flush; abandons an in-flight operation
//   busy       : operation in progress; HI/LO not yet valid
//   hi, lo     : HI/LO registers
//   dbg_state  : current FSM state (IDLE=0, MUL_RUN=1, DIV_RUN=2, FIXUP=3)
//
// Handshake: a request is taken on a rising edge where start=1, busy=0 and
// cancel=0. There is no ready signal; the issuer must hold off while busy=1.
// Any start seen while busy=1 is ignored. cancel overrides start.

module multiply_divide_unit #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        start,
  input  logic [2:0]  operation,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state
);

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  localparam int ITER = 32 / BITS_PER_CYCLE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    FIXUP   = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Working registers. For multiply, acc_hi is the running high word and
  // acc_lo starts as the multiplier and fills with product bits from the top.
  // For divide, acc_hi is the partial remainder and acc_lo starts as the
  // dividend and fills with quotient bits from the bottom.
  logic [31:0] acc_hi, acc_lo;
  logic [31:0] mcand;        // multiplicand or divisor magnitude
  logic        res_mul;      // result in acc is a 64-bit product
  logic        neg_hi;       // negate high word (or whole product)
  logic        neg_lo;       // negate low word (quotient)
  logic [4:0]  count;

  // Request decode
  logic        accept;
  logic        op_mul, op_div, op_signed;
  logic        sign1, sign2;
  logic [31:0] mag1, mag2;
  logic        div_zero;
  logic        last_iter;

  assign accept    = start && !cancel && (state_q == IDLE);
  assign op_mul    = (operation == MDU_MULT) || (operation == MDU_MULTU);
  assign op_div    = (operation == MDU_DIV)  || (operation == MDU_DIVU);
  assign op_signed = (operation == MDU_MULT) || (operation == MDU_DIV);
  assign sign1     = op_signed && operand1[31];
  assign sign2     = op_signed && operand2[31];
  // 0x80000000 negates to itself, which is also its correct unsigned magnitude.
  assign mag1      = sign1 ? (32'd0 - operand1) : operand1;
  assign mag2      = sign2 ? (32'd0 - operand2) : operand2;
  assign div_zero  = (operand2 == 32'd0);
  assign last_iter = (count == 5'(ITER - 1));

`ifdef MDU_FAST_MULTIPLY_EN
  // Extending to 64 bits and keeping the low 64 bits of the product gives the
  // correct result for both signed and unsigned multiplication.
  logic [63:0] ext1, ext2, fast_product;
  assign ext1         = {{32{sign1}}, operand1};
  assign ext2         = {{32{sign2}}, operand2};
  assign fast_product = ext1 * ext2;
`endif

  // One iteration step of BITS_PER_CYCLE bits for both algorithms.
  logic [31:0] mul_hi_n, mul_lo_n, div_rem_n, div_quo_n;
  logic [32:0] mul_sum, div_shift, div_diff;

  always_comb begin
    mul_hi_n  = acc_hi;
    mul_lo_n  = acc_lo;
    div_rem_n = acc_hi;
    div_quo_n = acc_lo;
    mul_sum   = 33'd0;
    div_shift = 33'd0;
    div_diff  = 33'd0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      // Shift-add: add multiplicand when the current multiplier bit is set,
      // then shift {carry, hi, lo} right by one.
      mul_sum  = {1'b0, mul_hi_n} + (mul_lo_n[0] ? {1'b0, mcand} : 33'd0);
      mul_lo_n = {mul_sum[0], mul_lo_n[31:1]};
      mul_hi_n = mul_sum[32:1];
      // Restoring divide: bring down the next dividend bit, trial subtract.
      div_shift = {div_rem_n, div_quo_n[31]};
      div_diff  = div_shift - {1'b0, mcand};
      if (!div_diff[32]) begin
        div_rem_n = div_diff[31:0];
        div_quo_n = {div_quo_n[30:0], 1'b1};
      end else begin
        div_rem_n = div_shift[31:0];
        div_quo_n = {div_quo_n[30:0], 1'b0};
      end
    end
  end

  // Sign fixup of the finished magnitudes.
  logic [63:0] product, product_neg;
  logic [31:0] fix_hi, fix_lo;

  always_comb begin
    product     = {acc_hi, acc_lo};
    product_neg = 64'd0 - product;
    fix_hi      = acc_hi;
    fix_lo      = acc_lo;
    if (res_mul) begin
      {fix_hi, fix_lo} = neg_hi ? product_neg : product;
    end else begin
      fix_hi = neg_hi ? (32'd0 - acc_hi) : acc_hi;
      fix_lo = neg_lo ? (32'd0 - acc_lo) : acc_lo;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && op_mul) begin
`ifdef MDU_FAST_MULTIPLY_EN
          state_d = FIXUP;
`else
          state_d = MUL_RUN;
`endif
        end else if (accept && op_div) begin
          state_d = div_zero ? FIXUP : DIV_RUN;
        end
      end
      MUL_RUN, DIV_RUN: begin
        if (cancel)         state_d = IDLE;
        else if (last_iter) state_d = FIXUP;
      end
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and architectural HI/LO
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      acc_hi  <= 32'd0;
      acc_lo  <= 32'd0;
      mcand   <= 32'd0;
      res_mul <= 1'b0;
      neg_hi  <= 1'b0;
      neg_lo  <= 1'b0;
      count   <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            count <= 5'd0;
            if (operation == MDU_MTHI) begin
              hi <= operand1;
            end else if (operation == MDU_MTLO) begin
              lo <= operand1;
            end else if (op_mul) begin
              res_mul <= 1'b1;
              neg_lo  <= 1'b0;
`ifdef MDU_FAST_MULTIPLY_EN
              acc_hi  <= fast_product[63:32];
              acc_lo  <= fast_product[31:0];
              neg_hi  <= 1'b0;
`else
              acc_hi  <= 32'd0;
              acc_lo  <= mag2;
              mcand   <= mag1;
              neg_hi  <= sign1 ^ sign2;
`endif
            end else if (op_div) begin
              res_mul <= 1'b0;
              if (div_zero) begin
                // Divide by zero bypasses iteration; FIXUP writes these as-is.
                acc_hi <= operand1;
                acc_lo <= 32'hFFFF_FFFF;
                neg_hi <= 1'b0;
                neg_lo <= 1'b0;
              end else begin
                acc_hi <= 32'd0;
                acc_lo <= mag1;
                mcand  <= mag2;
                neg_hi <= sign1;          // remainder follows the dividend
                neg_lo <= sign1 ^ sign2;  // quotient sign
              end
            end
          end
        end
        MUL_RUN: begin
          acc_hi <= mul_hi_n;
          acc_lo <= mul_lo_n;
          count  <= count + 5'd1;
        end
        DIV_RUN: begin
          acc_hi <= div_rem_n;
          acc_lo <= div_quo_n;
          count  <= count + 5'd1;
        end
        FIXUP: begin
          if (!cancel) begin
            hi <= fix_hi;
            lo <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multiply_divide_unit.sv
// tb_multiply_divide_unit
//
// Directed bench for multiply_divide_unit. It drives a linear sequence of
// operations with hand-computed results and checks HI/LO, busy duration,
// cancel and asynchronous reset behaviour.

module tb_multiply_divide_unit;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

`ifdef MDU_FAST_MULTIPLY_EN
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_BUSY = 33;
`endif

  logic        clock;
  logic        resetN;
  logic        start;
  logic [2:0]  operation;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  int cmp_cnt  = 0;
  int fail_cnt = 0;
  int busy_n;

  multiply_divide_unit dut (
    .clock     (clock),
    .resetN    (resetN),
    .start     (start),
    .operation (operation),
    .operand1  (operand1),
    .operand2  (operand2),
    .cancel    (cancel),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, then count cycles with busy high (bounded).
  task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int n);
    @(negedge clock);
    start     = 1'b1;
    operation = op;
    operand1  = a;
    operand2  = b;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clock);
    end
  endtask

  initial begin
    resetN    = 1'b0;
    start     = 1'b0;
    cancel    = 1'b0;
    operation = 3'd0;
    operand1  = 32'd0;
    operand2  = 32'd0;
    repeat (3) @(negedge clock);

    // Reset state
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_state", {30'd0, dbg_state}, 32'd0);
    resetN = 1'b1;

    // MULT -2 * 3 = -6
    do_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, busy_n);
    check32("mult_busy", busy_n, MUL_BUSY);
    check32("mult_hi", hi, 32'hFFFF_FFFF);
    check32("mult_lo", lo, 32'hFFFF_FFFA);

    // MULTU max * max
    do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, busy_n);
    check32("multu_max_hi", hi, 32'hFFFF_FFFE);
    check32("multu_max_lo", lo, 32'h0000_0001);

    // MULTU 2^16 * 2^16 = 2^32
    do_op(MDU_MULTU, 32'h0001_0000, 32'h0001_0000, busy_n);
    check32("multu_pow_hi", hi, 32'h0000_0001);
    check32("multu_pow_lo", lo, 32'h0000_0000);

    // MULT (2^31-1) * -2^31 = -2^62 + 2^31
    do_op(MDU_MULT, 32'h7FFF_FFFF, 32'h8000_0000, busy_n);
    check32("mult_ext_hi", hi, 32'hC000_0000);
    check32("mult_ext_lo", lo, 32'h8000_0000);

    // DIV -7 / 2 = -3 rem -1
    do_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, busy_n);
    check32("div_busy", busy_n, 33);
    check32("div_neg_lo", lo, 32'hFFFF_FFFD);
    check32("div_neg_hi", hi, 32'hFFFF_FFFF);

    // DIV 7 / -2 = -3 rem 1
    do_op(MDU_DIV, 32'd7, 32'hFFFF_FFFE, busy_n);
    check32("div_negd_lo", lo, 32'hFFFF_FFFD);
    check32("div_negd_hi", hi, 32'd1);

    // DIVU 7 / 2 = 3 rem 1
    do_op(MDU_DIVU, 32'd7, 32'd2, busy_n);
    check32("divu_lo", lo, 32'd3);
    check32("divu_hi", hi, 32'd1);

    // DIVU 100 / 7 = 14 rem 2; DIV -100 / 7 = -14 rem -2
    do_op(MDU_DIVU, 32'd100, 32'd7, busy_n);
    check32("divu100_lo", lo, 32'd14);
    check32("divu100_hi", hi, 32'd2);
    do_op(MDU_DIV, 32'hFFFF_FF9C, 32'd7, busy_n);
    check32("div_m100_lo", lo, 32'hFFFF_FFF2);
    check32("div_m100_hi", hi, 32'hFFFF_FFFE);

    // Signed overflow
    do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, busy_n);
    check32("div_ovf_lo", lo, 32'h8000_0000);
    check32("div_ovf_hi", hi, 32'd0);

    // Divide by zero, unsigned and signed
    do_op(MDU_DIVU, 32'd5, 32'd0, busy_n);
    check32("divu0_busy", busy_n, 1);
    check32("divu0_lo", lo, 32'hFFFF_FFFF);
    check32("divu0_hi", hi, 32'd5);
    do_op(MDU_DIV, 32'hFFFF_FFF9, 32'd0, busy_n);
    check32("div0_busy", busy_n, 1);
    check32("div0_lo", lo, 32'hFFFF_FFFF);
    check32("div0_hi", hi, 32'hFFFF_FFF9);

    // MTLO / MTHI: immediate, no busy
    do_op(MDU_MTLO, 32'h5555, 32'd0, busy_n);
    check32("mtlo_busy", busy_n, 0);
    check32("mtlo_lo", lo, 32'h5555);
    do_op(MDU_MTHI, 32'h1234, 32'd0, busy_n);
    check32("mthi_busy", busy_n, 0);
    check32("mthi_hi", hi, 32'h1234);

    // cancel together with start while idle: nothing accepted
    @(negedge clock);
    start = 1'b1; cancel = 1'b1; operation = MDU_MTLO; operand1 = 32'h7777;
    @(negedge clock);
    start = 1'b0; cancel = 1'b0;
    check32("idle_cancel_lo", lo, 32'h5555);
    check32("idle_cancel_busy", {31'd0, busy}, 32'd0);

    // DIV 100 / 7 cancelled at cycle 10; a start during busy is ignored
    @(negedge clock);
    start = 1'b1; operation = MDU_DIV; operand1 = 32'd100; operand2 = 32'd7;
    @(negedge clock);
    start = 1'b0;
    check32("cancel_busy_on", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clock);
    start = 1'b1; operation = MDU_MTHI; operand1 = 32'hDEAD;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    check32("cancel_busy_off", {31'd0, busy}, 32'd0);
    check32("cancel_hi", hi, 32'h1234);
    check32("cancel_lo", lo, 32'h5555);
    repeat (40) @(negedge clock);
    check32("cancel_hi_later", hi, 32'h1234);
    check32("cancel_lo_later", lo, 32'h5555);

    // Asynchronous reset mid-divide
    @(negedge clock);
    start = 1'b1; operation = MDU_DIVU; operand1 = 32'd1000; operand2 = 32'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    resetN = 1'b0;
    #1;
    check32("areset_hi", hi, 32'd0);
    check32("areset_lo", lo, 32'd0);
    check32("areset_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    resetN = 1'b1;
    do_op(MDU_MTLO, 32'hABCD, 32'd0, busy_n);
    check32("post_reset_lo", lo, 32'hABCD);
    check32("post_reset_hi", hi, 32'd0);
    check32("post_reset_busy", busy_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
